// File: rtl/test_finish_monitor_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : test_finish_monitor_pkg
//  Description : Shared definitions for the end-of-test monitor: the
//                status/state encoding seen on the status port, default
//                TOHOST and signature-window addresses, and a small width
//                helper used to size internal counters.
//  Revision    : 1.0 - initial release
// ============================================================================
package test_finish_monitor_pkg;

    // Encoding is visible on the status output and must stay stable.
    typedef enum logic [2:0] {
        ST_RUN     = 3'd0,
        ST_PASS    = 3'd1,
        ST_FAIL    = 3'd2,
        ST_TIMEOUT = 3'd3,
        ST_HALTED  = 3'd4
    } state_e;

    localparam logic [31:0] DEFAULT_TOHOST_ADDR = 32'h0000_1000;
    localparam logic [31:0] DEFAULT_SIG_BASE    = 32'h0000_1100;

    // Number of bits needed to hold the values 0..n (never less than 1).
    function automatic int unsigned width_for(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/test_finish_monitor_pc_stall_detector.sv
`default_nettype none
// ============================================================================
//  Module      : test_finish_monitor_pc_stall_detector
//  Description : Tracks the previous fetch address, counts consecutive cycles
//                in which the fetch address did not change and flags a stall
//                once the count reaches STALL_CYCLES-1 with the PC still equal.
//  Ports       : clk        - system clock, rising edge
//                reset      - asynchronous active-high reset
//                rom_addr   - CPU fetch address (PC)
//                stall_hit  - PC unchanged for STALL_CYCLES consecutive cycles
//                pc_changed - rom_addr differs from last cycle's value
//  Revision    : 1.0 - initial release
// ============================================================================
module test_finish_monitor_pc_stall_detector
    import test_finish_monitor_pkg::*;
#(
    parameter int unsigned STALL_CYCLES = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] rom_addr,
    output logic        stall_hit,
    output logic        pc_changed
);

    localparam int unsigned CNT_MAX = (STALL_CYCLES == 0) ? 0 : STALL_CYCLES - 1;
    localparam int unsigned CW      = width_for(CNT_MAX);
    localparam logic [CW-1:0] C_CNT_MAX = CW'(CNT_MAX);

    logic [31:0]   prev_pc_q,   prev_pc_d;
    logic [CW-1:0] stall_cnt_q, stall_cnt_d;
    logic          same_pc;

    always_comb begin
        same_pc     = (rom_addr == prev_pc_q);
        prev_pc_d   = rom_addr;
        stall_cnt_d = '0;
        if (same_pc) begin
            // Saturate so a long self-loop keeps the hit condition asserted.
            stall_cnt_d = (stall_cnt_q == C_CNT_MAX) ? stall_cnt_q
                                                     : stall_cnt_q + CW'(1);
        end
        pc_changed = !same_pc;
        stall_hit  = (STALL_CYCLES != 0) && same_pc && (stall_cnt_q == C_CNT_MAX);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_pc_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            prev_pc_q   <= prev_pc_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/test_finish_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : test_finish_monitor
//  Description : End-of-test monitor watching the CPU fetch and data-write
//                buses. A write to TOHOST ends the test (1 = pass, anything
//                else = fail with code data>>1); writes into the signature
//                window are captured; a RUN-cycle timeout and a PC self-loop
//                detector terminate hung programs. Terminal states are sticky
//                until reset. All outputs are registered.
//  Ports       : clk, reset            - clock / async active-high reset
//                rom_addr              - CPU fetch address
//                mem_wr_sig, mem_addr,
//                mem_wr_data           - CPU data write bus
//                done/pass/fail/timeout/halted - termination flags
//                status                - state encoding (RUN..HALTED)
//                fail_code             - data>>1 of the failing TOHOST write
//                cycle_count           - RUN cycles elapsed (saturating)
//                fetch_count           - cycles with a PC change (saturating)
//                sig_valid, sig_data   - signature slots and their valid bits
//  Revision    : 1.0 - initial release
// ============================================================================
module test_finish_monitor
    import test_finish_monitor_pkg::*;
#(
    parameter logic [31:0] TOHOST_ADDR    = DEFAULT_TOHOST_ADDR,
    parameter logic [31:0] SIG_BASE       = DEFAULT_SIG_BASE,
    parameter int unsigned NUM_SIG        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned STALL_CYCLES   = 8,
    parameter int unsigned CNT_W          = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           rom_addr,
    input  logic                  mem_wr_sig,
    input  logic [31:0]           mem_addr,
    input  logic [31:0]           mem_wr_data,
    output logic                  done,
    output logic                  pass,
    output logic                  fail,
    output logic                  timeout,
    output logic                  halted,
    output logic [2:0]            status,
    output logic [31:0]           fail_code,
    output logic [CNT_W-1:0]      cycle_count,
    output logic [CNT_W-1:0]      fetch_count,
    output logic [NUM_SIG-1:0]    sig_valid,
    output logic [NUM_SIG*32-1:0] sig_data
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
    // Compared in 64 bits so a narrow counter can never alias a large limit.
    localparam logic [63:0] C_TO_LAST =
        (TIMEOUT_CYCLES == 0) ? 64'd0 : 64'(TIMEOUT_CYCLES - 1);

    state_e                state_q,       state_d;
    logic [31:0]           fail_code_q,   fail_code_d;
    logic [CNT_W-1:0]      cycle_count_q, cycle_count_d;
    logic [CNT_W-1:0]      fetch_count_q, fetch_count_d;
    logic [NUM_SIG-1:0]    sig_valid_q,   sig_valid_d;
    logic [NUM_SIG*32-1:0] sig_data_q,    sig_data_d;
    logic                  pass_q,    pass_d;
    logic                  fail_q,    fail_d;
    logic                  timeout_q, timeout_d;
    logic                  halted_q,  halted_d;
    logic                  done_q,    done_d;

    logic        stall_hit;
    logic        pc_changed;
    logic        tohost_wr;
    logic        timeout_hit;
    logic [31:0] sig_offset;

    test_finish_monitor_pc_stall_detector #(
        .STALL_CYCLES (STALL_CYCLES)
    ) u_stall (
        .clk        (clk),
        .reset      (reset),
        .rom_addr   (rom_addr),
        .stall_hit  (stall_hit),
        .pc_changed (pc_changed)
    );

    // A single offset compare per slot covers both the window bounds and
    // word alignment: only exact multiples of 4 below 4*NUM_SIG match.
    assign sig_offset  = mem_addr - SIG_BASE;
    assign tohost_wr   = mem_wr_sig && (mem_addr == TOHOST_ADDR);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (64'(cycle_count_q) == C_TO_LAST);

    always_comb begin
        state_d       = state_q;
        fail_code_d   = fail_code_q;
        cycle_count_d = cycle_count_q;
        fetch_count_d = fetch_count_q;
        sig_valid_d   = sig_valid_q;
        sig_data_d    = sig_data_q;

        if (state_q == ST_RUN) begin
            for (int i = 0; i < int'(NUM_SIG); i++) begin
                if (mem_wr_sig && (sig_offset == 32'(4 * i))) begin
                    sig_data_d[32*i +: 32] = mem_wr_data;
                    sig_valid_d[i]         = 1'b1;
                end
            end

            if (pc_changed && (fetch_count_q != C_CNT_MAX)) begin
                fetch_count_d = fetch_count_q + CNT_W'(1);
            end

            // TOHOST outranks timeout and stall detected in the same cycle.
            if (tohost_wr) begin
                if (mem_wr_data == 32'd1) begin
                    state_d = ST_PASS;
                end else begin
                    state_d     = ST_FAIL;
                    fail_code_d = mem_wr_data >> 1;
                end
            end else if (timeout_hit) begin
                state_d = ST_TIMEOUT;
            end else if (stall_hit) begin
                state_d = ST_HALTED;
            end else if (cycle_count_q != C_CNT_MAX) begin
                cycle_count_d = cycle_count_q + CNT_W'(1);
            end
        end

        pass_d    = (state_d == ST_PASS);
        fail_d    = (state_d == ST_FAIL);
        timeout_d = (state_d == ST_TIMEOUT);
        halted_d  = (state_d == ST_HALTED);
        done_d    = (state_d != ST_RUN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_RUN;
            fail_code_q   <= '0;
            cycle_count_q <= '0;
            fetch_count_q <= '0;
            sig_valid_q   <= '0;
            sig_data_q    <= '0;
            pass_q        <= 1'b0;
            fail_q        <= 1'b0;
            timeout_q     <= 1'b0;
            halted_q      <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            fail_code_q   <= fail_code_d;
            cycle_count_q <= cycle_count_d;
            fetch_count_q <= fetch_count_d;
            sig_valid_q   <= sig_valid_d;
            sig_data_q    <= sig_data_d;
            pass_q        <= pass_d;
            fail_q        <= fail_d;
            timeout_q     <= timeout_d;
            halted_q      <= halted_d;
            done_q        <= done_d;
        end
    end

    assign status      = state_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign fail        = fail_q;
    assign timeout     = timeout_q;
    assign halted      = halted_q;
    assign fail_code   = fail_code_q;
    assign cycle_count = cycle_count_q;
    assign fetch_count = fetch_count_q;
    assign sig_valid   = sig_valid_q;
    assign sig_data    = sig_data_q;

endmodule
`default_nettype wire

// File: tb/tb_test_finish_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_test_finish_monitor
//  Description : Three monitor instances (default limits, short timeout,
//                narrow counters with timeout/stall disabled) driven by the
//                same bus stimulus and compared every cycle against a
//                behavioural model of the termination rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_test_finish_monitor;

    localparam logic [31:0] TOHOST = 32'h0000_1000;
    localparam logic [31:0] SIGB   = 32'h0000_1100;
    localparam int          NSIG   = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] rom_addr, mem_addr, mem_wr_data;
    logic        mem_wr_sig;

    always #5 clk = ~clk;

    logic a_done, a_pass, a_fail, a_to, a_halt;
    logic [2:0] a_status;
    logic [31:0] a_fcode, a_cyc, a_fet;
    logic [3:0] a_sv;
    logic [127:0] a_sd;

    logic t_done, t_pass, t_fail, t_to, t_halt;
    logic [2:0] t_status;
    logic [31:0] t_fcode, t_cyc, t_fet;
    logic [3:0] t_sv;
    logic [127:0] t_sd;

    logic s_done, s_pass, s_fail, s_to, s_halt;
    logic [2:0] s_status;
    logic [31:0] s_fcode;
    logic [3:0] s_cyc, s_fet;
    logic [3:0] s_sv;
    logic [127:0] s_sd;

    test_finish_monitor dut_a (
        .clk(clk), .reset(reset), .rom_addr(rom_addr), .mem_wr_sig(mem_wr_sig),
        .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .done(a_done), .pass(a_pass),
        .fail(a_fail), .timeout(a_to), .halted(a_halt), .status(a_status),
        .fail_code(a_fcode), .cycle_count(a_cyc), .fetch_count(a_fet),
        .sig_valid(a_sv), .sig_data(a_sd));

    test_finish_monitor #(.TIMEOUT_CYCLES(20)) dut_t (
        .clk(clk), .reset(reset), .rom_addr(rom_addr), .mem_wr_sig(mem_wr_sig),
        .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .done(t_done), .pass(t_pass),
        .fail(t_fail), .timeout(t_to), .halted(t_halt), .status(t_status),
        .fail_code(t_fcode), .cycle_count(t_cyc), .fetch_count(t_fet),
        .sig_valid(t_sv), .sig_data(t_sd));

    test_finish_monitor #(.CNT_W(4), .TIMEOUT_CYCLES(0), .STALL_CYCLES(0)) dut_s (
        .clk(clk), .reset(reset), .rom_addr(rom_addr), .mem_wr_sig(mem_wr_sig),
        .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .done(s_done), .pass(s_pass),
        .fail(s_fail), .timeout(s_to), .halted(s_halt), .status(s_status),
        .fail_code(s_fcode), .cycle_count(s_cyc), .fetch_count(s_fet),
        .sig_valid(s_sv), .sig_data(s_sd));

    // ---------------------------------------------------------------- model
    // st: 0 run, 1 pass, 2 fail, 3 timeout, 4 halted
    typedef struct {
        int              st;
        longint unsigned cyc;
        longint unsigned fet;
        logic [31:0]     prev;
        int unsigned     eqrun;   // consecutive earlier cycles with equal PC
        logic [31:0]     fcode;
        logic [127:0]    sig;
        logic [3:0]      sv;
    } mdl_t;

    mdl_t ma, mt, ms;

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.st = 0; m.cyc = 0; m.fet = 0; m.prev = 32'd0; m.eqrun = 0;
        m.fcode = 32'd0; m.sig = '0; m.sv = '0;
        return m;
    endfunction

    function automatic mdl_t mdl_next(input mdl_t m, input int unsigned to_cyc,
                                      input int unsigned stall_cyc, input int cw);
        longint unsigned cmax;
        bit same;
        int idx;
        cmax = (64'd1 << cw) - 1;
        same = (rom_addr == m.prev);
        if (m.st == 0) begin
            if (mem_wr_sig && mem_addr >= SIGB && mem_addr < SIGB + 4 * NSIG
                && mem_addr[1:0] == 2'b00) begin
                idx = int'((mem_addr - SIGB) / 4);
                m.sig[idx*32 +: 32] = mem_wr_data;
                m.sv[idx] = 1'b1;
            end
            if (!same && m.fet < cmax) m.fet = m.fet + 1;
            if (mem_wr_sig && mem_addr == TOHOST) begin
                if (mem_wr_data == 32'd1) m.st = 1;
                else begin
                    m.st = 2;
                    m.fcode = mem_wr_data / 2;
                end
            end else if (to_cyc != 0 && m.cyc == longint'(to_cyc) - 1) begin
                m.st = 3;
            end else if (stall_cyc != 0 && same && m.eqrun >= stall_cyc - 1) begin
                m.st = 4;
            end else if (m.cyc < cmax) begin
                m.cyc = m.cyc + 1;
            end
        end
        m.eqrun = same ? m.eqrun + 1 : 0;
        m.prev  = rom_addr;
        return m;
    endfunction

    // ------------------------------------------------------------- checking
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_dut(input string nm, input mdl_t m, input logic dn, input logic ps,
                             input logic fl, input logic to, input logic ht,
                             input logic [2:0] stt, input logic [31:0] fc,
                             input logic [31:0] cc, input logic [31:0] fe,
                             input logic [3:0] sv, input logic [127:0] sd);
        check({nm, ".status"},      stt, 128'(m.st));
        check({nm, ".done"},        dn,  128'(m.st != 0));
        check({nm, ".pass"},        ps,  128'(m.st == 1));
        check({nm, ".fail"},        fl,  128'(m.st == 2));
        check({nm, ".timeout"},     to,  128'(m.st == 3));
        check({nm, ".halted"},      ht,  128'(m.st == 4));
        check({nm, ".fail_code"},   fc,  m.fcode);
        check({nm, ".cycle_count"}, cc,  128'(m.cyc));
        check({nm, ".fetch_count"}, fe,  128'(m.fet));
        check({nm, ".sig_valid"},   sv,  m.sv);
        check({nm, ".sig_data"},    sd,  m.sig);
    endtask

    task automatic check_all();
        check_dut("a", ma, a_done, a_pass, a_fail, a_to, a_halt, a_status, a_fcode,
                  a_cyc, a_fet, a_sv, a_sd);
        check_dut("t", mt, t_done, t_pass, t_fail, t_to, t_halt, t_status, t_fcode,
                  t_cyc, t_fet, t_sv, t_sd);
        check_dut("s", ms, s_done, s_pass, s_fail, s_to, s_halt, s_status, s_fcode,
                  32'(s_cyc), 32'(s_fet), s_sv, s_sd);
    endtask

    // ------------------------------------------------------------- stimulus
    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input logic [31:0] pc, input logic wr,
                        input logic [31:0] addr, input logic [31:0] data);
        rom_addr = pc; mem_wr_sig = wr; mem_addr = addr; mem_wr_data = data;
        @(posedge clk);
        if (!reset) begin
            ma = mdl_next(ma, 1000, 8, 32);
            mt = mdl_next(mt, 20, 8, 32);
            ms = mdl_next(ms, 0, 0, 4);
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic step_pc(input logic [31:0] pc);
        step(pc, 1'b0, 32'd0, 32'd0);
    endtask

    // Asserts reset between clock edges so its asynchronous effect is seen.
    task automatic apply_reset();
        #2 reset = 1'b1;
        #1;
        ma = mdl_reset(); mt = mdl_reset(); ms = mdl_reset();
        check_all();
        mem_wr_sig = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_all();
    endtask

    initial begin
        logic [31:0] pc;
        logic        wr;
        logic [31:0] addr, data;
        int          sel, hold_pct;

        reset = 1'b1; rom_addr = 32'd0; mem_wr_sig = 1'b0; mem_addr = 32'd0; mem_wr_data = 32'd0;
        ma = mdl_reset(); mt = mdl_reset(); ms = mdl_reset();
        @(negedge clk);
        @(negedge clk);
        check("rst.status", a_status, 0);
        check("rst.done", a_done, 0);
        check_all();
        reset = 1'b0;

        // Passing program with two signature writes, TOHOST at cycle 40.
        for (int i = 0; i <= 40; i++) begin
            if (i == 5)       step(32'h100 + 4 * i, 1'b1, SIGB, 32'd5);
            else if (i == 9)  step(32'h100 + 4 * i, 1'b1, SIGB + 4, 32'd55);
            else if (i == 40) step(32'h100 + 4 * i, 1'b1, TOHOST, 32'd1);
            else              step_pc(32'h100 + 4 * i);
        end
        check("pass.pass", a_pass, 1);
        check("pass.done", a_done, 1);
        check("pass.slot0", a_sd[31:0], 5);
        check("pass.slot1", a_sd[63:32], 55);
        check("pass.sig_valid", a_sv, 4'b0011);
        check("pass.cycle_count", a_cyc, 40);
        step(32'h300, 1'b1, SIGB + 8, 32'd9);
        step(32'h304, 1'b1, TOHOST, 32'd6);
        check("pass.sticky_sv", a_sv, 4'b0011);
        check("pass.sticky_pass", a_pass, 1);

        // Failing TOHOST write, later pass write ignored.
        apply_reset();
        for (int i = 0; i < 10; i++) step_pc(32'h200 + 4 * i);
        step(32'h300, 1'b1, TOHOST, 32'h7);
        check("fail.fail", a_fail, 1);
        check("fail.code", a_fcode, 3);
        check("fail.pass", a_pass, 0);
        check("fail.status", a_status, 2);
        step(32'h304, 1'b1, TOHOST, 32'd1);
        check("fail.ignored_pass", a_pass, 0);

        // Timeout on the TIMEOUT_CYCLES=20 instance, saturation on CNT_W=4.
        apply_reset();
        for (int i = 0; i < 30; i++) begin
            step_pc(32'h400 + 4 * i);
            if (i == 18) check("to.before", t_to, 0);
            if (i == 19) begin
                check("to.expired", t_to, 1);
                check("to.cycle_count", t_cyc, 19);
            end
        end
        check("sat.cycle_count", s_cyc, 15);
        check("sat.done", s_done, 0);
        apply_reset();
        for (int i = 0; i < 19; i++) step_pc(32'h400 + 4 * i);
        step(32'h500, 1'b1, TOHOST, 32'd1);
        check("to.race_pass", t_pass, 1);
        check("to.race_timeout", t_to, 0);

        // PC self-loop.
        apply_reset();
        step_pc(32'h40);
        for (int i = 0; i < 7; i++) step_pc(32'h40);
        check("stall.not_yet", a_halt, 0);
        step_pc(32'h40);
        check("stall.halted", a_halt, 1);
        apply_reset();
        step_pc(32'h40);
        for (int i = 0; i < 7; i++) step_pc(32'h40);
        step_pc(32'h44);
        for (int i = 0; i < 4; i++) step_pc(32'h48 + 4 * i);
        check("stall.run_halt", a_halt, 0);
        check("stall.run_status", a_status, 0);

        // Window edges, then reset mid-run after captures.
        apply_reset();
        step(32'h600, 1'b1, SIGB, 32'hA);
        step(32'h604, 1'b1, SIGB + 8, 32'hB);
        check("sig.two", a_sv, 4'b0101);
        step(32'h608, 1'b1, SIGB + 2, 32'hC);
        step(32'h60C, 1'b1, SIGB + 16, 32'hD);
        check("sig.ignored", a_sv, 4'b0101);
        #2 reset = 1'b1;
        #1;
        check("mid.sig_valid", a_sv, 0);
        check("mid.sig_data", a_sd, 0);
        check("mid.fetch_count", a_fet, 0);
        ma = mdl_reset(); mt = mdl_reset(); ms = mdl_reset();
        @(negedge clk);
        reset = 1'b0;
        step_pc(32'h700);
        check("mid.status", a_status, 0);

        // Randomized episodes.
        pc = 32'h800;
        for (int ep = 0; ep < 10; ep++) begin
            apply_reset();
            hold_pct = (ep % 2 == 0) ? 30 : 85;
            for (int i = 0; i < 80; i++) begin
                if ($urandom_range(0, 99) >= hold_pct) begin
                    pc = ($urandom_range(0, 4) == 0) ? ($urandom & 32'hFFFC) : pc + 4;
                end
                wr = ($urandom_range(0, 2) == 0);
                sel = $urandom_range(0, 9);
                case (sel)
                    0:       addr = TOHOST;
                    1, 2, 3: addr = SIGB + 4 * $urandom_range(0, 3);
                    4, 5:    addr = SIGB + $urandom_range(0, 19);
                    6:       addr = SIGB + 16;
                    default: addr = $urandom;
                endcase
                data = (sel == 0 && $urandom_range(0, 1) == 1) ? 32'd1 : $urandom;
                step(pc, wr, addr, data);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/test_finish_monitor.md
Name: test_finish_monitor

Overview:
Synthesizable, parametrised end-of-test monitor that observes the CPU instruction-fetch and data-write buses. It replaces a fixed simulation run length and manual register inspection with bus-driven termination:
- a write to a TOHOST address ends the test with pass or fail;
- writes to a signature window are captured;
- a cycle timeout and a PC-stall (self-loop) detector catch hung programs.

It sits beside cpu/rom/ram in the system top and in the CPU bench. Its status outputs drive $finish in simulation and LEDs on the didactic board.

Parameters:
TOHOST_ADDR, 32'h0000_1000, byte address whose write terminates the test
SIG_BASE, 32'h0000_1100, byte address of signature slot 0 (word aligned)
NUM_SIG, 4, number of 32-bit signature slots (1..16)
TIMEOUT_CYCLES, 1000, RUN cycles before TIMEOUT; 0 disables
STALL_CYCLES, 8, consecutive cycles with unchanged rom_addr before HALTED; 0 disables
CNT_W, 32, width of cycle and fetch counters

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
rom_addr  in  32  CPU fetch address (PC)
mem_wr_sig  in  1  CPU data write strobe
mem_addr  in  32  CPU data byte address
mem_wr_data  in  32  CPU write data
done  out  1  test finished (any terminal state), sticky
pass  out  1  TOHOST written with 1
fail  out  1  TOHOST written with any other value
timeout  out  1  timeout expired
halted  out  1  PC stall detected
status  out  3  state encoding (from parameters.vh)
fail_code  out  32  mem_wr_data>>1 of the failing TOHOST write, else 0
cycle_count  out  CNT_W  RUN cycles elapsed, saturating
fetch_count  out  CNT_W  cycles where rom_addr changed, saturating
sig_valid  out  NUM_SIG  slot i written at least once
sig_data  out  NUM_SIG*32  slot i at bits [32*i+31:32*i]

Behaviour:
- Reset (async assert, released synchronously by the driving logic):
  - all outputs 0; state = RUN.
  - Stall reference register loads 0; stall counter 0.
- States: RUN, PASS, FAIL, TIMEOUT, HALTED. PASS, FAIL, TIMEOUT and HALTED are terminal and sticky until reset.
- All outputs are registered. A triggering event sampled at edge k is visible after edge k.
- In RUN, each cycle (priority high to low):
  1. mem_wr_sig && mem_addr==TOHOST_ADDR:
     - mem_wr_data==1 -> PASS.
     - otherwise -> FAIL, fail_code <= mem_wr_data>>1.
  2. TIMEOUT_CYCLES!=0 && cycle_count==TIMEOUT_CYCLES-1 -> TIMEOUT.
  3. STALL_CYCLES!=0 && stall counter==STALL_CYCLES-1 && rom_addr==previous rom_addr -> HALTED.
  4. otherwise stay in RUN; cycle_count++.
- A TOHOST write coinciding with the timeout or stall condition resolves to PASS/FAIL.
- Signature capture:
  - Condition: in RUN, mem_wr_sig && mem_addr in [SIG_BASE, SIG_BASE+4*NUM_SIG) && mem_addr[1:0]==0.
  - Action: slot (mem_addr-SIG_BASE)>>2 <= mem_wr_data; sig_valid bit set.
  - Misaligned or out-of-window writes are ignored.
  - Rewrites overwrite the slot.
  - Captures still occur in the same cycle as a TOHOST write.
- Stall counter:
  - increments when rom_addr equals the registered previous value, else clears to 0;
  - saturates at STALL_CYCLES-1.
- fetch_count increments in RUN when rom_addr differs from its previous value.
- Counters saturate at all-ones, never wrap.
- In terminal states: counters freeze; signature, TOHOST and stall inputs are ignored.
- done = pass|fail|timeout|halted. Exactly one of these four is set after termination.
- Reset mid-test: immediate return to the reset values above; signatures are cleared.

Decomposition:
- parameters.vh (shared header):
  - state/status encodings (RUN=0, PASS=1, FAIL=2, TIMEOUT=3, HALTED=4);
  - default TOHOST_ADDR and SIG_BASE constants.
- One sub-module: pc_stall_detector. It holds the previous-PC register, the stall counter and the fetch-change pulse, parametrised by STALL_CYCLES, and outputs stall_hit and pc_changed.
- The FSM, counters and signature bank stay in the top module.

Test Plan:
- Program writes 5 to SIG_BASE, 55 to SIG_BASE+4, then 1 to TOHOST at cycle 40 -> pass=1 and done=1 one cycle later; sig_data slot0=5, slot1=55; sig_valid=4'b0011; cycle_count frozen at 40.
- TOHOST written with 32'h7 -> fail=1, fail_code=3, pass=0, status=FAIL; later TOHOST write of 1 ignored.
- TIMEOUT_CYCLES=20, no TOHOST write, PC advancing -> timeout=1 after 20 RUN cycles, cycle_count=19; TOHOST write of 1 in the expiry cycle instead -> pass=1, timeout=0.
- STALL_CYCLES=8, rom_addr held at 32'h40 ("j .") -> halted=1 after 8 equal-PC cycles; hold of 7 cycles then change -> remains RUN.
- Misaligned write to SIG_BASE+2 and write to SIG_BASE+4*NUM_SIG -> no sig_valid change; reset asserted mid-RUN after captures -> all outputs 0 asynchronously, status=RUN after release.
- CNT_W=4, TIMEOUT_CYCLES=0, STALL_CYCLES=0, 30 cycles -> cycle_count saturates at 15, no terminal state.
